ms_timer_bank: RTL and testbench
================================

// Module: ms_timer_bank
// PURPOSE
//   Bank of N_CH independent millisecond timers sharing one clock. Each channel
//   runs one-shot countdown, auto-reload countdown or count-up stopwatch, with
//   pause, abort and a one-cycle expiry pulse. Serves game/UI timing logic that
//   previously needed one single-mode countdown instance per timeout.
// PARAMETERS
//   N_CH        4      number of channels
//   MAX_MS      2047   largest ms value; W = $clog2(MAX_MS+1) (localparam)
//   CLKS_PER_MS 50000  clk cycles per ms (50 MHz clk)
// PORTS
//   clk          in   1        system clock, all logic on rising edge
//   rst_n        in   1        synchronous, active-low reset
//   start        in   N_CH     per-channel load/start pulse
//   stop         in   N_CH     per-channel abort pulse
//   pause        in   N_CH     per-channel level; 1 = hold count and prescaler
//   mode         in   2*N_CH   ch i at [2i+1:2i]: 00 one-shot, 01 reload, 10 up, 11 = 00
//   start_value  in   W*N_CH   ch i at [W*i+:W]; captured on start
//   timer_value  out  W*N_CH   ch i current ms count, registered
//   running      out  N_CH     1 while channel in RUN or PAUSED
//   expired      out  N_CH     one-cycle pulse on expiry/reload/saturation
// BEHAVIOUR
// - Reset (rst_n=0 at edge): all channels IDLE; timer_value, running, expired,
//   prescalers, captured reload values = 0. Reset mid-run suppresses any pulse.
// - Per channel: private prescaler 0..CLKS_PER_MS-1, captured mode and reload
//   value; FSM IDLE, RUN, PAUSED, DONE. mode/start_value only sampled on start.
// - Priority per edge: rst_n > stop > start > pause > count.
// - stop (any state): -> IDLE, timer_value=0, prescaler=0, no expired pulse.
// - start (any state, incl. RUN/PAUSED/DONE = restart): prescaler=0; count =
//   start_value (down modes) or 0 (up); -> RUN; running=1 after same edge.
// - Down mode, start_value=0: -> DONE at that edge, expired=1 next cycle;
//   reload mode with 0 behaves as one-shot (no per-cycle pulsing).
// - RUN, pause=0: prescaler+1 each cycle; at CLKS_PER_MS-1 it wraps to 0 and
//   a ms tick occurs same edge. First tick = CLKS_PER_MS cycles after start.
// - RUN, pause=1: -> PAUSED; prescaler and count frozen. PAUSED, pause=0 ->
//   RUN, counting resumes from frozen prescaler (no lost/extra cycles).
// - Tick, one-shot: count-1; when 1->0: expired=1, -> DONE, running=0.
// - Tick, reload: count-1; when 1->0: count loads captured value instead of 0
//   (0 never visible), expired=1, stay RUN. Period = value*CLKS_PER_MS.
// - Tick, up: count+1; on reaching MAX_MS: saturate, expired=1, -> DONE.
// - DONE: count held, running=0; only start/stop/reset leave it.
// - All outputs registered; expired high exactly one cycle per event.
// - Channels fully independent; simultaneous events on several channels allowed.
// CONFIGURATION
// - `define MS_TIMER_STICKY_EN: adds ports expired_clr in N_CH and
//   expired_flag out N_CH. expired_flag[i] set on every expired[i] pulse, cleared
//   by expired_clr[i]; set wins if same cycle; reset clears it. Flag survives
//   stop/start/restart.
// - Without it: those ports and flops absent; all other behaviour identical.
// TESTING (bench: N_CH=4, MAX_MS=7, CLKS_PER_MS=4; edge E0 = start sampled)
// 1. ch0 mode 00, value 3 -> count 3,2,1,0 at E0,E4,E8,E12; expired=1 for the
//    cycle after E12 only; running 1 from E0 to E12.
// 2. ch1 mode 01, value 2 -> expired pulses after E8,E16,E24; count 2,1,2,1...;
//    running stays 1; stop at E20 -> count 0, running 0, no further pulses.
// 3. ch2 mode 00, value 2, pause=1 for 5 cycles from E2 -> expiry at E13.
// 4. ch3 mode 10 -> counts 0..7, saturates at 7 at E28 with one expired pulse,
//    holds 7 in DONE; further cycles no pulses.
// 5. start+stop same cycle -> IDLE, count 0; start with value 0, mode 00 ->
//    expired after E0, state DONE; rst_n=0 mid-run -> all outputs 0 next edge.
// 6. MS_TIMER_STICKY_EN: flag set by test 1 expiry, held through restart;
//    clr with concurrent expiry keeps 1; clr alone -> 0 next cycle.

Source files
------------

// File: rtl/ms_timer_bank.sv
// ms_timer_bank: bank of N_CH independent millisecond timers (one-shot, auto-reload, count-up).
// Latency: all outputs registered; start takes effect at the sampling edge, and expiry pulses in the cycle after the tick edge.
// Backpressure: none; start/stop are single-cycle pulses, and the pause level freezes a channel in place.
// Ports: clk, rst_n (synchronous, active-low); start/stop/pause (1 bit per channel);
//        mode (2 bits per channel); start_value and timer_value (W bits per channel);
//        running and expired (1 bit per channel).
// Option: `define MS_TIMER_STICKY_EN adds input expired_clr and output expired_flag (sticky expiry).
module ms_timer_bank #(
    parameter int N_CH        = 4,
    parameter int MAX_MS      = 2047,
    parameter int CLKS_PER_MS = 50000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_CH-1:0]                  start,
    input  logic [N_CH-1:0]                  stop,
    input  logic [N_CH-1:0]                  pause,
    input  logic [2*N_CH-1:0]                mode,
    input  logic [$clog2(MAX_MS+1)*N_CH-1:0] start_value,
    output logic [$clog2(MAX_MS+1)*N_CH-1:0] timer_value,
    output logic [N_CH-1:0]                  running,
    output logic [N_CH-1:0]                  expired
`ifdef MS_TIMER_STICKY_EN
    ,
    input  logic [N_CH-1:0]                  expired_clr,
    output logic [N_CH-1:0]                  expired_flag
`endif
);
    localparam int W  = $clog2(MAX_MS + 1);
    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

    localparam logic [PW-1:0] PRE_LAST    = PW'(CLKS_PER_MS - 1);
    localparam logic [W-1:0]  CNT_PRE_MAX = W'(MAX_MS - 1);
    localparam logic [W-1:0]  CNT_ONE     = W'(1);

    localparam logic [1:0] M_ONESHOT = 2'b00;
    localparam logic [1:0] M_RELOAD  = 2'b01;
    localparam logic [1:0] M_UP      = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

    state_t         st_q    [N_CH];
    state_t         st_d    [N_CH];
    logic [PW-1:0]  presc_q [N_CH];
    logic [PW-1:0]  presc_d [N_CH];
    logic [W-1:0]   cnt_q   [N_CH];
    logic [W-1:0]   cnt_d   [N_CH];
    logic [W-1:0]   rld_q   [N_CH];
    logic [W-1:0]   rld_d   [N_CH];
    logic [1:0]     mode_q  [N_CH];
    logic [1:0]     mode_d  [N_CH];
    logic [1:0]     mode_in [N_CH];
    logic [W-1:0]   val_in  [N_CH];
    logic [N_CH-1:0] run_d;
    logic [N_CH-1:0] exp_d;

    // Next-state per channel; priority stop > start > pause > count.
    always_comb begin
        run_d = '0;
        exp_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            st_d[i]    = st_q[i];
            presc_d[i] = presc_q[i];
            cnt_d[i]   = cnt_q[i];
            rld_d[i]   = rld_q[i];
            mode_d[i]  = mode_q[i];
            mode_in[i] = mode[2*i +: 2];
            val_in[i]  = start_value[W*i +: W];

            if (stop[i]) begin
                st_d[i]    = S_IDLE;
                presc_d[i] = '0;
                cnt_d[i]   = '0;
            end else if (start[i]) begin
                presc_d[i] = '0;
                mode_d[i]  = (mode_in[i] == 2'b11) ? M_ONESHOT : mode_in[i];
                rld_d[i]   = val_in[i];
                if (mode_d[i] == M_UP) begin
                    cnt_d[i] = '0;
                    st_d[i]  = S_RUN;
                end else if (val_in[i] == '0) begin
                    // A zero countdown expires immediately, reload included,
                    // so a reload channel never pulses every cycle.
                    cnt_d[i] = '0;
                    st_d[i]  = S_DONE;
                    exp_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = val_in[i];
                    st_d[i]  = S_RUN;
                end
            end else if (st_q[i] == S_RUN || st_q[i] == S_PAUSED) begin
                if (pause[i]) begin
                    st_d[i] = S_PAUSED;
                end else begin
                    // Leaving PAUSED counts on the same edge, so no cycle is lost.
                    st_d[i] = S_RUN;
                    if (presc_q[i] != PRE_LAST) begin
                        presc_d[i] = presc_q[i] + 1'b1;
                    end else begin
                        presc_d[i] = '0;
                        if (mode_q[i] == M_UP) begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                            if (cnt_q[i] == CNT_PRE_MAX) begin
                                st_d[i]  = S_DONE;
                                exp_d[i] = 1'b1;
                            end
                        end else if (cnt_q[i] == CNT_ONE) begin
                            exp_d[i] = 1'b1;
                            if (mode_q[i] == M_RELOAD) begin
                                // Jump straight to the reload value; 0 is never shown.
                                cnt_d[i] = rld_q[i];
                            end else begin
                                cnt_d[i] = '0;
                                st_d[i]  = S_DONE;
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i] - 1'b1;
                        end
                    end
                end
            end
            run_d[i] = (st_d[i] == S_RUN) || (st_d[i] == S_PAUSED);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= '{default: S_IDLE};
            presc_q <= '{default: '0};
            cnt_q   <= '{default: '0};
            rld_q   <= '{default: '0};
            mode_q  <= '{default: '0};
            running <= '0;
            expired <= '0;
        end else begin
            st_q    <= st_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            rld_q   <= rld_d;
            mode_q  <= mode_d;
            running <= run_d;
            expired <= exp_d;
        end
    end

    always_comb begin
        timer_value = '0;
        for (int i = 0; i < N_CH; i++) begin
            timer_value[W*i +: W] = cnt_q[i];
        end
    end

`ifdef MS_TIMER_STICKY_EN
    // The flag rises with the expired pulse; a set and a clear in the same cycle leave it set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            expired_flag <= '0;
        end else begin
            expired_flag <= exp_d | (expired_flag & ~expired_clr);
        end
    end
`endif

endmodule

// File: tb/tb_ms_timer_bank.sv
`timescale 1ns/1ps
module tb_ms_timer_bank;
    localparam int N_CH   = 4;
    localparam int MAX_MS = 7;
    localparam int CLKS   = 4;
    localparam int W      = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N_CH-1:0]     start = '0;
    logic [N_CH-1:0]     stop = '0;
    logic [N_CH-1:0]     pause = '0;
    logic [2*N_CH-1:0]   mode = '0;
    logic [W*N_CH-1:0]   start_value = '0;
    logic [W*N_CH-1:0]   timer_value;
    logic [N_CH-1:0]     running;
    logic [N_CH-1:0]     expired;
`ifdef MS_TIMER_STICKY_EN
    logic [N_CH-1:0]     expired_clr = '0;
    logic [N_CH-1:0]     expired_flag;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: timer state derived from "active" (unpaused) cycles since start.
    int m_st  [N_CH];   // 0 idle, 1 running/paused, 2 done
    int m_md  [N_CH];
    int m_val [N_CH];
    int m_act [N_CH];
    int m_cnt [N_CH];
    bit m_exp [N_CH];
    bit m_flag[N_CH];

    always #5 clk = ~clk;

    ms_timer_bank #(.N_CH(N_CH), .MAX_MS(MAX_MS), .CLKS_PER_MS(CLKS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
        .pause(pause),
        .mode(mode),
        .start_value(start_value),
        .timer_value(timer_value),
        .running(running),
        .expired(expired)
`ifdef MS_TIMER_STICKY_EN
        ,
        .expired_clr(expired_clr),
        .expired_flag(expired_flag)
`endif
    );

    task automatic model_step();
        for (int i = 0; i < N_CH; i++) begin
            int md;
            int ms;
            m_exp[i] = 1'b0;
            if (!rst_n || stop[i]) begin
                m_st[i]  = 0;
                m_cnt[i] = 0;
            end else if (start[i]) begin
                md = int'(mode[2*i +: 2]);
                if (md == 3) md = 0;
                m_md[i]  = md;
                m_val[i] = int'(start_value[W*i +: W]);
                m_act[i] = 0;
                if (md == 2) begin
                    m_st[i] = 1; m_cnt[i] = 0;
                end else if (m_val[i] == 0) begin
                    m_st[i] = 2; m_cnt[i] = 0; m_exp[i] = 1'b1;
                end else begin
                    m_st[i] = 1; m_cnt[i] = m_val[i];
                end
            end else if (m_st[i] == 1 && !pause[i]) begin
                m_act[i]++;
                ms = m_act[i] / CLKS;
                case (m_md[i])
                    0: begin
                        m_cnt[i] = m_val[i] - ms;
                        if (m_cnt[i] == 0) begin m_st[i] = 2; m_exp[i] = 1'b1; end
                    end
                    1: begin
                        m_cnt[i] = m_val[i] - (ms % m_val[i]);
                        if ((m_act[i] % CLKS) == 0 && (ms % m_val[i]) == 0) m_exp[i] = 1'b1;
                    end
                    default: begin
                        m_cnt[i] = ms;
                        if (ms == MAX_MS) begin m_st[i] = 2; m_exp[i] = 1'b1; end
                    end
                endcase
            end
`ifdef MS_TIMER_STICKY_EN
            if (!rst_n) m_flag[i] = 1'b0;
            else        m_flag[i] = m_exp[i] | (m_flag[i] & ~expired_clr[i]);
`endif
        end
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int cnt_of(input int ch);
        return int'(timer_value[W*ch +: W]);
    endfunction

    task automatic go(input int ch, input int md, input int val);
        start = '0;
        start[ch] = 1'b1;
        mode[2*ch +: 2] = 2'(md);
        start_value[W*ch +: W] = W'(val);
        tick_cycle();
        start = '0;
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N_CH; i++) begin
                n_checks += 3;
                if (int'(timer_value[W*i +: W]) != m_cnt[i]) begin
                    n_fail++;
                    $display("FAIL model_cnt ch%0d t=%0t: got %0d expected %0d", i, $time, timer_value[W*i +: W], m_cnt[i]);
                end
                if (running[i] != (m_st[i] == 1)) begin
                    n_fail++;
                    $display("FAIL model_running ch%0d t=%0t: got %0d expected %0d", i, $time, running[i], (m_st[i] == 1));
                end
                if (expired[i] != m_exp[i]) begin
                    n_fail++;
                    $display("FAIL model_expired ch%0d t=%0t: got %0d expected %0d", i, $time, expired[i], m_exp[i]);
                end
`ifdef MS_TIMER_STICKY_EN
                n_checks++;
                if (expired_flag[i] != m_flag[i]) begin
                    n_fail++;
                    $display("FAIL model_flag ch%0d t=%0t: got %0d expected %0d", i, $time, expired_flag[i], m_flag[i]);
                end
`endif
            end
        end
    end

    initial begin
        for (int i = 0; i < N_CH; i++) begin
            m_st[i] = 0; m_md[i] = 0; m_val[i] = 0; m_act[i] = 0;
            m_cnt[i] = 0; m_exp[i] = 1'b0; m_flag[i] = 1'b0;
        end
        #1;
        rst_n = 1'b0;
        tick_cycle();
        tick_cycle();
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("reset_tv", int'(timer_value), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_expired", int'(expired), 0);

        // 1: one-shot 3 on ch0
        go(0, 0, 3);
        chk("t1_e0_cnt", cnt_of(0), 3);
        chk("t1_e0_run", int'(running[0]), 1);
        for (int e = 1; e <= 13; e++) begin
            tick_cycle();
            if (e == 4)  chk("t1_e4_cnt", cnt_of(0), 2);
            if (e == 11) chk("t1_e11_exp", int'(expired[0]), 0);
            if (e == 12) begin
                chk("t1_e12_cnt", cnt_of(0), 0);
                chk("t1_e12_exp", int'(expired[0]), 1);
                chk("t1_e12_run", int'(running[0]), 0);
`ifdef MS_TIMER_STICKY_EN
                chk("t6_flag_set", int'(expired_flag[0]), 1);
`endif
            end
            if (e == 13) chk("t1_e13_exp", int'(expired[0]), 0);
        end
`ifdef MS_TIMER_STICKY_EN
        expired_clr[0] = 1'b1;
        tick_cycle();
        expired_clr[0] = 1'b0;
        chk("t6_flag_clr", int'(expired_flag[0]), 0);
`endif

        // 2: reload 2 on ch1, stop at E20
        go(1, 1, 2);
        chk("t2_e0_cnt", cnt_of(1), 2);
        for (int e = 1; e <= 30; e++) begin
            stop[1] = (e == 20);
            tick_cycle();
            if (e == 8)  begin chk("t2_e8_exp", int'(expired[1]), 1); chk("t2_e8_cnt", cnt_of(1), 2); end
            if (e == 9)  chk("t2_e9_exp", int'(expired[1]), 0);
            if (e == 12) chk("t2_e12_cnt", cnt_of(1), 1);
            if (e == 16) chk("t2_e16_exp", int'(expired[1]), 1);
            if (e == 20) begin chk("t2_stop_cnt", cnt_of(1), 0); chk("t2_stop_run", int'(running[1]), 0); end
        end
        stop = '0;

        // 3: one-shot 2 on ch2 with pause sampled E2..E6
        go(2, 0, 2);
        for (int e = 1; e <= 14; e++) begin
            pause[2] = (e >= 2 && e <= 6);
            tick_cycle();
            if (e == 4)  chk("t3_paused_run", int'(running[2]), 1);
            if (e == 12) chk("t3_e12_exp", int'(expired[2]), 0);
            if (e == 13) begin chk("t3_e13_exp", int'(expired[2]), 1); chk("t3_e13_cnt", cnt_of(2), 0); end
        end
        pause = '0;

        // 4: count-up on ch3, saturates at 7
        go(3, 2, 5);
        chk("t4_e0_cnt", cnt_of(3), 0);
        for (int e = 1; e <= 34; e++) begin
            tick_cycle();
            if (e == 4)  chk("t4_e4_cnt", cnt_of(3), 1);
            if (e == 28) begin chk("t4_e28_cnt", cnt_of(3), 7); chk("t4_e28_exp", int'(expired[3]), 1); end
            if (e == 29) begin chk("t4_e29_exp", int'(expired[3]), 0); chk("t4_e29_run", int'(running[3]), 0); end
            if (e == 34) chk("t4_hold_cnt", cnt_of(3), 7);
        end

        // 5: start+stop, zero-value start, reset mid-run
        start[0] = 1'b1; stop[0] = 1'b1; mode[1:0] = 2'b00; start_value[2:0] = 3'd5;
        tick_cycle();
        start = '0; stop = '0;
        chk("t5_ss_cnt", cnt_of(0), 0);
        chk("t5_ss_run", int'(running[0]), 0);
        go(0, 0, 0);
        chk("t5_zero_exp", int'(expired[0]), 1);
        chk("t5_zero_run", int'(running[0]), 0);
        tick_cycle();
        chk("t5_zero_exp2", int'(expired[0]), 0);
        go(1, 1, 1);
        for (int e = 1; e <= 3; e++) tick_cycle();
        rst_n = 1'b0;
        tick_cycle();
        rst_n = 1'b1;
        chk("t5_rst_tv", int'(timer_value), 0);
        chk("t5_rst_run", int'(running), 0);
        chk("t5_rst_exp", int'(expired), 0);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N_CH; i++) begin
                start[i] = ($urandom_range(0, 59) == 0);
                stop[i]  = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 9) == 0) pause[i] = ~pause[i];
`ifdef MS_TIMER_STICKY_EN
                expired_clr[i] = ($urandom_range(0, 3) == 0);
`endif
            end
            mode        = 8'($urandom);
            start_value = 12'($urandom);
            rst_n       = ($urandom_range(0, 799) != 0);
            tick_cycle();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
